// File: rtl/divmod_pkg.sv
// Shared types and sizing helpers for the iterative divide/modulus unit.
package divmod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DIVMOD_WIDTH_DEFAULT = 64;

    // Iteration counter width; sized for WIDTH+1 so WIDTH itself is representable.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divmod_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module divmod_step
    import divmod_pkg::*;
#(
    parameter int WIDTH = DIVMOD_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             quot_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor on entry, so the shifted value fits WIDTH+1 bits and the result fits WIDTH.
    always_comb begin
        shifted  = {rem, bit_in};
        diff     = shifted - {1'b0, divisor};
        quot_bit = (shifted >= {1'b0, divisor});
        rem_next = quot_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divmod_iter.sv
// Iterative valid/ready divide/modulus, one quotient bit per clock.
// Define DIVMOD_SIGNED_EN to enable per-operation signed mode (adds the SIGN state).
module divmod_iter
    import divmod_pkg::*;
#(
    parameter int WIDTH = DIVMOD_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic             out_div_zero
);

    localparam int              CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic             ready_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem_next;
    logic             quot_bit;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

`ifdef DIVMOD_SIGNED_EN
    logic sign_a;
    logic sign_b;
    logic neg_quot;
    logic neg_rem;

    always_comb begin
        sign_a = in_signed & in_a[WIDTH-1];
        sign_b = in_signed & in_b[WIDTH-1];
        mag_a  = sign_a ? (~in_a + 1'b1) : in_a;
        mag_b  = sign_b ? (~in_b + 1'b1) : in_b;
    end
`else
    logic unused_signed;

    assign unused_signed = in_signed;

    always_comb begin
        mag_a = in_a;
        mag_b = in_b;
    end
`endif

    // Ready is forced low while reset is held, not only after the reset edge.
    assign in_ready = ready_q & ~rst;

    divmod_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem),
        .bit_in  (dvd[WIDTH-1]),
        .divisor (dsr),
        .rem_next(rem_next),
        .quot_bit(quot_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ready_q      <= 1'b1;
            cnt          <= '0;
            out_valid    <= 1'b0;
            out_quot     <= '0;
            out_rem      <= '0;
            out_div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        ready_q <= 1'b0;
                        cnt     <= '0;
                        rem     <= '0;
                        dvd     <= mag_a;
                        dsr     <= mag_b;
`ifdef DIVMOD_SIGNED_EN
                        neg_quot <= sign_a ^ sign_b;
                        neg_rem  <= sign_a;
`endif
                        if (in_b == '0) begin
                            out_quot     <= '1;
                            out_rem      <= in_a;
                            out_div_zero <= 1'b1;
                            out_valid    <= 1'b1;
                            state        <= DONE;
                        end else begin
                            out_div_zero <= 1'b0;
                            state        <= CALC;
                        end
                    end
                end
                CALC: begin
                    // The dividend register shifts out its MSB and collects quotient bits at the LSB.
                    rem <= rem_next;
                    dvd <= {dvd[WIDTH-2:0], quot_bit};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
`ifdef DIVMOD_SIGNED_EN
                        state <= SIGN;
`else
                        out_quot  <= {dvd[WIDTH-2:0], quot_bit};
                        out_rem   <= rem_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
`endif
                    end
                end
`ifdef DIVMOD_SIGNED_EN
                SIGN: begin
                    // Most-negative / -1 wraps back to most-negative here with no special case.
                    out_quot  <= neg_quot ? (~dvd + 1'b1) : dvd;
                    out_rem   <= neg_rem ? (~rem + 1'b1) : rem;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ready_q   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/divmod_iter.md
# divmod_iter

Iterative, handshaked integer divide/modulus unit computing quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock. It is the successor to the combinational 64-bit modulus in the CPU ALU path. It is parametrised in width, adds a quotient output, divide-by-zero reporting and an optional signed mode, and replaces a long combinational path with a WIDTH-cycle sequential datapath behind valid/ready.

## Interface
- WIDTH, 64, operand/result width; legal range 2..128
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  unit can accept; high only in IDLE
- in_a  in  WIDTH  dividend
- in_b  in  WIDTH  divisor
- in_signed  in  1  treat operands as two's complement; ignored unless DIVMOD_SIGNED_EN
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- out_quot  out  WIDTH  quotient
- out_rem  out  WIDTH  remainder (modulus)
- out_div_zero  out  1  in_b was zero for this result

## Operation
- States: IDLE, CALC, SIGN (only with DIVMOD_SIGNED_EN), DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture operands, clear the iteration counter, and go to CALC; if in_b==0, go to DONE directly.
- CALC: restoring division, MSB first. Each cycle: shift {rem,dividend} left by one; if rem >= divisor, subtract and set the quotient LSB to 1. The partial remainder is WIDTH+1 bits internally. After WIDTH iterations, go to SIGN if present, else DONE.
- SIGN: negate the quotient if operand signs differ; negate the remainder if the dividend was negative. Then go to DONE.
- DONE: out_valid=1. Outputs are stable while out_valid&&!out_ready. On out_ready, go to IDLE.
- Divide by zero: out_quot all ones, out_rem = in_a, out_div_zero=1.
- Signed overflow (a = most-negative, b = -1): out_quot = a, out_rem = 0, out_div_zero=0. This falls out of the magnitude datapath and the SIGN fix-up; no special case is required.
- Unsigned results equal a/b and a%b exactly. Signed results truncate toward zero; the remainder takes the dividend's sign.
- New operands are never accepted while a result is pending (no overlap, depth 1).

## Timing
- Reset: in_ready=0 during rst, 1 on the first cycle after rst deasserts. out_valid=0, out_quot=0, out_rem=0, out_div_zero=0. FSM goes to IDLE.
- Reset mid-operation (CALC/SIGN/DONE) abandons the operation; no result is emitted.
- Latency, counted from the accept edge to the first cycle with out_valid=1:
  - Unsigned build: WIDTH cycles.
  - Signed build: WIDTH+1 cycles in both modes, so latency does not depend on in_signed.
  - Divide by zero: 1 cycle.
- Throughput: one operation per WIDTH+2 cycles (unsigned build) when out_ready is held high. in_ready rises the cycle after the out_valid&&out_ready edge.
- out_ready held low: out_valid stays high indefinitely with no change to outputs.
- in_valid may toggle freely while in_ready=0; it is ignored.

## Configuration
- DIVMOD_SIGNED_EN defined: signed mode available. in_signed selects the mode per operation. Operands are converted to magnitudes on accept, and the SIGN state is present.
- DIVMOD_SIGNED_EN undefined: unsigned only. The in_signed port remains but is ignored. There is no SIGN state and latency is WIDTH.

## Structure
- Shared package divmod_pkg holds:
  - state enum typedef: IDLE, CALC, SIGN, DONE
  - DIVMOD_WIDTH_DEFAULT = 64
  - counter width derived as $clog2(WIDTH+1)
- One sub-module, divmod_step: a combinational single restoring step. It takes the partial remainder, the next dividend bit and the divisor, and returns the next remainder and the quotient bit. The top level holds the FSM, the registers and the handshake.

## Test plan
- WIDTH=64, a=100, b=7, out_ready=1: quotient 14, remainder 2, div_zero=0. out_valid first seen exactly 64 cycles after the accept edge (65 in a signed build).
- a=0xDEAD, b=0: after 1 cycle, quotient all ones, remainder 0xDEAD, div_zero=1.
- Signed build, in_signed=1, a=-7, b=2: quotient -3, remainder -1. With a=7, b=-2: quotient -3, remainder 1. With a = most-negative, b=-1: quotient = most-negative, remainder 0.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. Outputs stay stable, in_ready stays 0, and a new in_valid is ignored. Release out_ready: in_ready=1 on the next cycle.
- Assert rst for one cycle at iteration 30. Outputs clear, no out_valid appears, and a following a=9, b=3 yields quotient 3, remainder 0.
- Randomised back-to-back stream (WIDTH=8 and WIDTH=64, random out_ready) checked against a/b and a%b.
